// File: rtl/apb_clk_meas_pkg.sv
// Shared definitions for the APB clock-count measurement master:
// counter register map, FSM encodings and the per-step transfer lookup.
package apb_clk_meas_pkg;

  localparam logic [31:0] OFF_START  = 32'h0;
  localparam logic [31:0] OFF_STOP   = 32'h4;
  localparam logic [31:0] OFF_STATUS = 32'h8;
  localparam logic [31:0] OFF_COUNT  = 32'hC;
  localparam int          STS_OVF_BIT = 1;

  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_WAIT, ST_RESULT} meas_state_e;

  typedef enum logic [1:0] {XS_IDLE, XS_SETUP, XS_ACCESS} xfer_state_e;

  typedef enum logic [2:0] {
    STEP_START, STEP_STOP, STEP_CLR_START, STEP_RD_CNT, STEP_RD_STS, STEP_CLR_STOP
  } step_e;

  typedef struct packed {
    logic [31:0] off;
    logic        write;
    logic [31:0] wdata;
  } step_cmd_t;

  function automatic step_cmd_t step_cmd(input step_e s);
    step_cmd_t c;
    c = '0;
    case (s)
      STEP_START:     c = '{off: OFF_START,  write: 1'b1, wdata: 32'd1};
      STEP_STOP:      c = '{off: OFF_STOP,   write: 1'b1, wdata: 32'd1};
      STEP_CLR_START: c = '{off: OFF_START,  write: 1'b1, wdata: 32'd0};
      STEP_RD_CNT:    c = '{off: OFF_COUNT,  write: 1'b0, wdata: 32'd0};
      STEP_RD_STS:    c = '{off: OFF_STATUS, write: 1'b0, wdata: 32'd0};
      STEP_CLR_STOP:  c = '{off: OFF_STOP,   write: 1'b1, wdata: 32'd0};
      default:        c = '0;
    endcase
    return c;
  endfunction

  function automatic step_e next_step(input step_e s);
    step_e n;
    case (s)
      STEP_START:     n = STEP_STOP;
      STEP_STOP:      n = STEP_CLR_START;
      STEP_CLR_START: n = STEP_RD_CNT;
      STEP_RD_CNT:    n = STEP_RD_STS;
      STEP_RD_STS:    n = STEP_CLR_STOP;
      default:        n = STEP_CLR_STOP;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/apb_master_xfer.sv
// Single APB transfer engine: SETUP then ACCESS until p_ready or timeout.
// A new go in the completing ACCESS cycle launches the next SETUP back-to-back.
module apb_master_xfer
  import apb_clk_meas_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        p_clk,
  input  logic        prst_n,
  input  logic        go,
  input  logic [31:0] addr,
  input  logic        write,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] p_addr,
  output logic        p_sel,
  output logic        p_en,
  output logic        p_write,
  output logic [31:0] p_wrdata,
  input  logic        p_ready,
  input  logic [31:0] p_rdata,
  input  logic        p_slverr
);

  localparam int TW = $clog2(TIMEOUT + 1);

  xfer_state_e   state_q, state_d;
  logic [TW-1:0] tmr_q;
  logic          acc, timeout, launch;

  assign acc     = (state_q == XS_ACCESS);
  assign timeout = acc && !p_ready && (tmr_q == '0);
  assign done    = (acc && p_ready) || timeout;
  assign err     = (acc && p_ready && p_slverr) || timeout;
  assign rdata   = p_rdata;
  assign launch  = go && ((state_q == XS_IDLE) || (acc && p_ready));

  always_comb begin
    state_d = state_q;
    case (state_q)
      XS_IDLE:   if (go) state_d = XS_SETUP;
      XS_SETUP:  state_d = XS_ACCESS;
      XS_ACCESS: begin
        if (launch)    state_d = XS_SETUP;
        else if (done) state_d = XS_IDLE;
      end
      default:   state_d = XS_IDLE;
    endcase
  end

  always_ff @(posedge p_clk) begin
    if (!prst_n) begin
      state_q  <= XS_IDLE;
      tmr_q    <= '0;
      p_addr   <= '0;
      p_sel    <= 1'b0;
      p_en     <= 1'b0;
      p_write  <= 1'b0;
      p_wrdata <= '0;
    end else begin
      state_q <= state_d;
      p_sel   <= (state_d != XS_IDLE);
      p_en    <= (state_d == XS_ACCESS);
      if (launch) begin
        p_addr   <= addr;
        p_write  <= write;
        p_wrdata <= wdata;
      end
      // timer holds the number of further ACCESS cycles allowed after this one
      if (state_q == XS_SETUP)
        tmr_q <= TW'(TIMEOUT - 1);
      else if (acc && !p_ready && (tmr_q != '0))
        tmr_q <= tmr_q - TW'(1);
    end
  end

endmodule

// File: rtl/apb_clk_meas_master.sv
// APB master running one start/window/stop/read/re-arm measurement per request
// on the clock-counter slave and returning count, overflow and error status.
//
//   state     | meaning
//   ST_IDLE   | ready for a request
//   ST_XFER   | a step's transfer is being issued or is in flight
//   ST_WAIT   | measurement window between START and STOP
//   ST_RESULT | result held on res_* until accepted
module apb_clk_meas_master
  import apb_clk_meas_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          WIN_W     = 16,
  parameter int          TIMEOUT   = 16
) (
  input  logic             p_clk,
  input  logic             prst_n,
  input  logic             req_valid,
  input  logic [WIN_W-1:0] req_window,
  output logic             req_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_count,
  output logic             res_ovf,
  output logic             res_err,
  output logic [31:0]      p_addr,
  output logic             p_sel,
  output logic             p_en,
  output logic             p_write,
  output logic [31:0]      p_wrdata,
  input  logic             p_ready,
  input  logic [31:0]      p_rdata,
  input  logic             p_slverr
);

  meas_state_e      state_q, state_d;
  step_e            step_q, step_d, go_step;
  logic [WIN_W-1:0] win_q, win_d;
  logic             go, done, err;
  logic [31:0]      rdata, go_addr;
  step_cmd_t        cmd;

  assign req_ready = (state_q == ST_IDLE);
  assign cmd       = step_cmd(go_step);
  assign go_addr   = BASE_ADDR + cmd.off;

  apb_master_xfer #(.TIMEOUT(TIMEOUT)) u_xfer (
    .p_clk    (p_clk),
    .prst_n   (prst_n),
    .go       (go),
    .addr     (go_addr),
    .write    (cmd.write),
    .wdata    (cmd.wdata),
    .done     (done),
    .rdata    (rdata),
    .err      (err),
    .p_addr   (p_addr),
    .p_sel    (p_sel),
    .p_en     (p_en),
    .p_write  (p_write),
    .p_wrdata (p_wrdata),
    .p_ready  (p_ready),
    .p_rdata  (p_rdata),
    .p_slverr (p_slverr)
  );

  // go_step looks one step ahead on completion so the next SETUP follows without a gap
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    win_d   = win_q;
    go      = 1'b0;
    go_step = step_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_XFER;
          step_d  = STEP_START;
          win_d   = req_window;
        end
      end
      ST_XFER: begin
        if (done) begin
          if (err || (step_q == STEP_CLR_STOP)) begin
            state_d = ST_RESULT;
          end else begin
            step_d = next_step(step_q);
            if ((step_q == STEP_START) && (win_q != '0)) begin
              state_d = ST_WAIT;
            end else begin
              go      = 1'b1;
              go_step = next_step(step_q);
            end
          end
        end else begin
          go = 1'b1;
        end
      end
      ST_WAIT: begin
        if (win_q == WIN_W'(1)) begin
          go      = 1'b1;
          state_d = ST_XFER;
        end else begin
          win_d = win_q - WIN_W'(1);
        end
      end
      ST_RESULT: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge p_clk) begin
    if (!prst_n) begin
      state_q   <= ST_IDLE;
      step_q    <= STEP_START;
      win_q     <= '0;
      res_valid <= 1'b0;
      res_count <= '0;
      res_ovf   <= 1'b0;
      res_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      win_q     <= win_d;
      res_valid <= (state_d == ST_RESULT);
      if ((state_q == ST_IDLE) && req_valid) begin
        res_count <= '0;
        res_ovf   <= 1'b0;
        res_err   <= 1'b0;
      end
      if ((state_q == ST_XFER) && done) begin
        if (err)
          res_err <= 1'b1;
        else if (step_q == STEP_RD_CNT)
          res_count <= rdata;
        else if (step_q == STEP_RD_STS)
          res_ovf <= rdata[STS_OVF_BIT];
      end
    end
  end

endmodule

// File: doc/apb_clk_meas_master.md
# apb_clk_meas_master

APB master that runs one complete clock-count measurement on the APB clock-counter slave per request. It sits directly upstream of the counter on the same APB segment. It issues the start, stop, read and re-arm transfer sequence, times the measurement window, and returns the captured count, overflow flag and error status on a valid/ready result port.

## Interface
- `BASE_ADDR`, default 32'h0: counter base address; all offsets are added to it.
- `WIN_W`, default 16: width of the window-length request field.
- `TIMEOUT`, default 16: maximum ACCESS cycles allowed without `p_ready` before a transfer is aborted.
- `p_clk` in 1: the only clock; everything is rising-edge.
- `prst_n` in 1: reset; synchronous, active-low.
- `req_valid` in 1: measurement request.
- `req_window` in WIN_W: window length in `p_clk` cycles between the START transfer and the STOP transfer.
- `req_ready` out 1: high only in IDLE.
- `res_valid` out 1: result available; held until accepted.
- `res_ready` in 1: result accept.
- `res_count` out 32: COUNT register value.
- `res_ovf` out 1: STATUS[1].
- `res_err` out 1: slave error or timeout occurred.
- `p_addr` out 32, `p_sel` out 1, `p_en` out 1, `p_write` out 1, `p_wrdata` out 32: APB master request.
- `p_ready` in 1, `p_rdata` in 32, `p_slverr` in 1: APB completion.

## Operation
- Counter register map (offsets from BASE_ADDR):
  - 0x0 START[0]
  - 0x4 STOP[0]
  - 0x8 STATUS[1] = overflow
  - 0xC COUNT[31:0]
- Top FSM states: IDLE → XFER ↔ WAIT → RESULT → IDLE.
- Request handshake: accepted when `req_valid && req_ready`. `req_window` is latched on acceptance.
- Step sequence, in order:
  - 0: WR 0x0 = 1
  - WAIT for `req_window` cycles
  - 1: WR 0x4 = 1
  - 2: WR 0x0 = 0
  - 3: RD 0xC → `res_count`
  - 4: RD 0x8 → `res_ovf` = `p_rdata[1]`
  - 5: WR 0x4 = 0 (re-arm; clears the counter)
- Each transfer is one SETUP cycle (`p_sel`=1, `p_en`=0) followed by ACCESS cycles (`p_sel`=1, `p_en`=1) until `p_ready`=1.
  - `p_addr`, `p_write` and `p_wrdata` are stable across both phases.
- Read data is captured only in the ACCESS cycle in which `p_ready`=1.
- `req_window`=0: the WAIT state is skipped; the STOP SETUP immediately follows the START completion cycle.
- `p_slverr`=1 in a completing cycle: remaining steps are aborted, `res_err`=1, go to RESULT. Fields not yet read hold 0.
- Timeout: after TIMEOUT ACCESS cycles without `p_ready`, drop `p_sel`/`p_en`, set `res_err`=1, go to RESULT.
- RESULT: `res_valid`=1 until `res_ready`=1, then IDLE on the next cycle.
  - `res_*` values are frozen while `res_valid`=1.
  - `req_valid` is ignored outside IDLE.
- Reset values:
  - Registered outputs (`p_addr`, `p_sel`, `p_en`, `p_write`, `p_wrdata`, `res_valid`, `res_count`, `res_ovf`, `res_err`) are 0.
  - State is IDLE.
  - `req_ready` = (state==IDLE), so it is 1 in the first cycle after reset.

## Timing
- APB outputs are registered; there is no combinational path from `p_ready`/`p_rdata` to APB outputs.
- With a zero-wait slave and acceptance at edge 0:
  - Step k SETUP is at cycle 1+2k, plus W for k≥1.
  - Last ACCESS is at cycle 12+W.
  - `res_valid` rises at cycle 13+W.
- Each slave wait state adds exactly one cycle.
- Reset asserted mid-transfer: on that edge `p_sel`/`p_en` go to 0 and the FSM enters IDLE. No partial result is ever presented.

## Structure
- `apb_clk_meas_pkg` holds:
  - The register offset localparams.
  - The top state enum.
  - The step enum (START, STOP, CLR_START, RD_CNT, RD_STS, CLR_STOP).
  - A per-step address/write/data lookup function.
- Sub-module `apb_master_xfer`: a single-transfer engine.
  - Inputs: go, addr, write, wdata.
  - Outputs: done, rdata, err (slverr or timeout).
  - Contains the SETUP/ACCESS FSM and the timeout counter.
- The top level holds only the step counter, the window counter and the result registers.

## Test plan
- Zero-wait slave model; `req_window`=5; model counts 7.
  - Expect 6 transfers at the addresses and data above, in order.
  - `res_valid` at cycle 18; `res_count`=7, `res_ovf`=0, `res_err`=0.
- `req_window`=0 → STOP SETUP immediately follows START ACCESS; `res_valid` at cycle 13.
- Slave inserts 2 wait states on RD 0xC → `p_addr`/`p_en` stable for 3 ACCESS cycles; `res_valid` delayed by exactly 2.
- `p_slverr`=1 on step 1 (STOP) → no further transfers; `res_err`=1, `res_count`=0, `res_valid` next cycle.
- `p_ready` stuck low with TIMEOUT=16 → `p_sel` drops after the 16th ACCESS cycle; `res_err`=1.
- `prst_n`=0 during step 3 ACCESS → next cycle all outputs are 0 and `req_ready`=1. A new request then runs the full sequence with STATUS[1]=1 returning `res_ovf`=1.
